// File: rtl/count_seq_pkg.sv
// Shared definitions for the count sequencer: default datapath width and FSM state encoding.
package count_seq_pkg;

   localparam int DEF_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/count_seq_dp.sv
// Count register with clear/hold/increment control and the terminal compare against the latched limit.
module count_seq_dp
   import count_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   input  logic [WIDTH-1:0] limit_q,
   output logic [WIDTH-1:0] count,
   output logic             term
);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc) begin
         count <= count + WIDTH'(1);
      end
   end

   assign term = (count == limit_q);

endmodule

// File: rtl/count_seq_ctrl.sv
// Start/stop/pause sequencer for the up counter: one-shot or periodic runs with a terminal-count pulse.
module count_seq_ctrl
   import count_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic             periodic,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             tc_pulse,
   output logic [1:0]       state
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] limit_q;
   logic             mode_q;
   logic             load, cnt_clr, cnt_inc, term, start_ok;

   // A zero limit would terminate every cycle, so it never launches a run.
   assign start_ok = start && (limit != '0);

   // NOTE: only control registers are reset here; there is no memory array needing a reset sweep.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         limit_q <= '0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load) begin
            limit_q <= limit;
            mode_q  <= periodic;
         end
      end
   end

   // NOTE: every output of this block is defaulted first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      if (stop) begin
         state_d = ST_IDLE;
         cnt_clr = 1'b1;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               cnt_clr = 1'b1;
               if (start_ok) begin
                  state_d = ST_RUN;
                  load    = 1'b1;
               end
            end
            ST_RUN: begin
               if (term) begin
                  if (mode_q) cnt_clr = 1'b1;
                  else        state_d = ST_DONE;
               end else if (pause) begin
                  state_d = ST_PAUSE;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
            ST_PAUSE: begin
               if (!pause) state_d = ST_RUN;
            end
            ST_DONE: begin
               if (start_ok) begin
                  state_d = ST_RUN;
                  load    = 1'b1;
                  cnt_clr = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   count_seq_dp #(.WIDTH(WIDTH)) u_dp (
      .clk     (clk),
      .reset   (reset),
      .clr     (cnt_clr),
      .inc     (cnt_inc),
      .limit_q (limit_q),
      .count   (count),
      .term    (term)
   );

   // Outputs decode straight from the state register so they carry no extra latency.
   assign busy     = (state_q == ST_RUN) || (state_q == ST_PAUSE);
   assign tc_pulse = (state_q == ST_RUN) && term;
   assign state    = state_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Scoreboard bench for count_seq_ctrl: driver pushes model expectations, monitor pops and compares.
module tb_count_seq_ctrl;

   logic       clk, reset, start, stop, pause, periodic;
   logic [3:0] limit, count;
   logic       busy, tc_pulse;
   logic [1:0] state;

   typedef struct {
      int cyc;
      int count;
      int state;
      int busy;
      int tc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_err = 0;

   // Reference model: run phase (0 idle, 1 run, 2 pause, 3 done), count, latched limit and mode.
   int   m_state = 0, m_count = 0, m_limit = 0, m_per = 0;

   count_seq_ctrl dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .stop     (stop),
      .pause    (pause),
      .periodic (periodic),
      .limit    (limit),
      .count    (count),
      .busy     (busy),
      .tc_pulse (tc_pulse),
      .state    (state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: compares every expectation whose cycle has arrived, sampled on the falling edge.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         exp_t e;
         e = sb.pop_front();
         check($sformatf("count@%0d", e.cyc), int'(count), e.count);
         check($sformatf("state@%0d", e.cyc), int'(state), e.state);
         check($sformatf("busy@%0d", e.cyc), int'(busy), e.busy);
         check($sformatf("tc_pulse@%0d", e.cyc), int'(tc_pulse), e.tc);
      end
   end

   function automatic void model_reset();
      m_state = 0;
      m_count = 0;
      m_limit = 0;
      m_per   = 0;
   endfunction

   function automatic void model_edge(input int st, input int sp, input int pa, input int pe, input int lim);
      bit launch;
      launch = (st != 0) && (lim != 0);
      if (sp != 0) begin
         m_state = 0;
         m_count = 0;
      end else if (m_state == 0 || m_state == 3) begin
         if (launch) begin
            m_state = 1;
            m_count = 0;
            m_limit = lim;
            m_per   = pe;
         end
      end else if (m_state == 1) begin
         if (m_count == m_limit) begin
            if (m_per != 0) m_count = 0;
            else            m_state = 3;
         end else if (pa != 0) begin
            m_state = 2;
         end else begin
            m_count = m_count + 1;
         end
      end else if (pa == 0) begin
         m_state = 1;
      end
   endfunction

   task automatic step(input int st, input int sp, input int pa, input int pe, input int lim);
      exp_t e;
      start    = st[0];
      stop     = sp[0];
      pause    = pa[0];
      periodic = pe[0];
      limit    = 4'(lim);
      model_edge(st, sp, pa, pe, lim);
      e.cyc   = cyc + 1;
      e.count = m_count;
      e.state = m_state;
      e.busy  = (m_state == 1 || m_state == 2) ? 1 : 0;
      e.tc    = (m_state == 1 && m_count == m_limit) ? 1 : 0;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, $urandom_range(0, 15));
   endtask

   task automatic async_rst();
      @(negedge clk);
      #2;
      start = 1'b0;
      stop  = 1'b0;
      pause = 1'b0;
      reset = 1'b0;
      #1;
      check("rst_count", int'(count), 0);
      check("rst_state", int'(state), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_tc", int'(tc_pulse), 0);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", n_checks);
      $fatal(1);
   end

   initial begin
      reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; periodic = 1'b0; limit = 4'd0;
      #1 reset = 1'b0;
      #1;
      check("init_count", int'(count), 0);
      check("init_state", int'(state), 0);
      check("init_busy", int'(busy), 0);
      check("init_tc", int'(tc_pulse), 0);
      model_reset();
      @(posedge clk);
      #1 reset = 1'b1;

      // One-shot to 5, then DONE holding 5.
      step(1, 0, 0, 0, 5);
      idle(8);
      // Periodic with limit 3 restarted straight from DONE.
      step(1, 0, 0, 1, 3);
      idle(12);
      step(0, 1, 0, 0, 0);
      // One-shot 9 with a 3-cycle pause at count 4.
      step(1, 0, 0, 0, 9);
      idle(4);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
      idle(8);
      // Pause asserted exactly in the terminal cycle of a periodic run.
      step(1, 0, 0, 1, 2);
      idle(2);
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      // Stop together with start mid-run, then a zero-limit start.
      step(1, 0, 0, 1, 9);
      idle(6);
      step(1, 1, 0, 1, 9);
      step(1, 0, 0, 1, 0);
      idle(2);
      // Asynchronous reset at count 7, then a full-range periodic run wrapping 15 -> 0.
      step(1, 0, 0, 0, 9);
      idle(7);
      async_rst();
      step(1, 0, 0, 1, 15);
      idle(20);
      step(0, 1, 0, 0, 0);

      // Randomized traffic, including mid-run limit/periodic churn and occasional resets.
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 199) == 0) async_rst();
         else step(($urandom_range(0, 3) == 0) ? 1 : 0,
                   ($urandom_range(0, 29) == 0) ? 1 : 0,
                   ($urandom_range(0, 5) == 0) ? 1 : 0,
                   int'($urandom_range(0, 1)),
                   int'($urandom_range(0, 15)));
      end

      idle(2);
      @(negedge clk);
      #1;
      check("sb_drain", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
